// File: rtl/task_dag_scheduler.sv
// Dependency-driven task issuer: launches each enabled task once all of its
// predecessors are DONE, with an in-flight cap, abort and deadlock detection.
module task_dag_scheduler #(
  parameter int unsigned NUM_TASKS    = 8,
  parameter int unsigned MAX_INFLIGHT = 4,
  parameter int unsigned CNT_W        = $clog2(NUM_TASKS + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           run_start,
  input  logic                           abort,
  input  logic [NUM_TASKS*NUM_TASKS-1:0] dep_matrix,
  input  logic [NUM_TASKS-1:0]           task_en,
  output logic [NUM_TASKS-1:0]           task_req,
  input  logic [NUM_TASKS-1:0]           task_ack,
  input  logic [NUM_TASKS-1:0]           task_done,
  output logic                           busy,
  output logic                           run_done,
  output logic                           run_error,
  output logic [CNT_W-1:0]               inflight,
  output logic [2*NUM_TASKS-1:0]         task_state
);

  localparam int unsigned DEP_W = NUM_TASKS * NUM_TASKS;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  localparam logic [1:0] T_WAIT    = 2'd0;
  localparam logic [1:0] T_ISSUED  = 2'd1;
  localparam logic [1:0] T_RUNNING = 2'd2;
  localparam logic [1:0] T_DONE    = 2'd3;

  state_t                          state_q, state_d;
  logic [NUM_TASKS-1:0][1:0]       ts_q, ts_d;
  logic [DEP_W-1:0]                deps_q, deps_d;
  logic [NUM_TASKS-1:0]            req_q, req_d;
  logic [CNT_W-1:0]                inflight_q, inflight_d;
  logic                            busy_q, busy_d;
  logic                            run_done_q, run_done_d;
  logic                            run_error_q, run_error_d;

  logic [NUM_TASKS-1:0]            elig;
  logic                            all_done_cur;
  logic                            all_done_nxt;
  logic                            issue;
  logic [CNT_W-1:0]                n_done;

  // Eligibility: WAIT and every predecessor DONE; a self-edge can never resolve.
  always_comb begin
    elig         = '0;
    all_done_cur = 1'b1;
    for (int i = 0; i < NUM_TASKS; i++) begin
      if (ts_q[i] != T_DONE) all_done_cur = 1'b0;
      elig[i] = (ts_q[i] == T_WAIT);
      for (int j = 0; j < NUM_TASKS; j++) begin
        if (deps_q[i*NUM_TASKS + j] && ((i == j) || (ts_q[j] != T_DONE)))
          elig[i] = 1'b0;
      end
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d      = state_q;
    ts_d         = ts_q;
    deps_d       = deps_q;
    req_d        = req_q;
    inflight_d   = inflight_q;
    run_done_d   = 1'b0;
    run_error_d  = 1'b0;
    issue        = 1'b0;
    n_done       = '0;
    all_done_nxt = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (run_start) begin
          state_d    = S_RUN;
          deps_d     = dep_matrix;
          req_d      = '0;
          inflight_d = '0;
          for (int i = 0; i < NUM_TASKS; i++)
            ts_d[i] = task_en[i] ? T_WAIT : T_DONE;
        end
      end

      S_RUN: begin
        if (abort) begin
          state_d    = S_IDLE;
          ts_d       = '0;
          req_d      = '0;
          inflight_d = '0;
        end else begin
          // Ack wins over a same-edge done for an ISSUED task.
          for (int i = 0; i < NUM_TASKS; i++) begin
            if (ts_q[i] == T_ISSUED && task_ack[i]) begin
              ts_d[i]  = T_RUNNING;
              req_d[i] = 1'b0;
            end else if (ts_q[i] == T_RUNNING && task_done[i]) begin
              ts_d[i] = T_DONE;
              n_done  = n_done + CNT_W'(1);
            end
          end

          // Lowest-index eligible task is issued, one per cycle, under the cap.
          if (inflight_q < CNT_W'(MAX_INFLIGHT)) begin
            for (int i = 0; i < NUM_TASKS; i++) begin
              if (!issue && elig[i]) begin
                ts_d[i]  = T_ISSUED;
                req_d[i] = 1'b1;
                issue    = 1'b1;
              end
            end
          end

          inflight_d = inflight_q + CNT_W'(issue) - n_done;

          all_done_nxt = 1'b1;
          for (int i = 0; i < NUM_TASKS; i++)
            if (ts_d[i] != T_DONE) all_done_nxt = 1'b0;

          if (all_done_nxt) begin
            state_d    = S_FINISH;
            run_done_d = 1'b1;
          end else if (inflight_q == '0 && elig == '0 && !all_done_cur) begin
            state_d     = S_IDLE;
            run_error_d = 1'b1;
            req_d       = '0;
          end
        end
      end

      S_FINISH: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ts_q        <= '0;
      deps_q      <= '0;
      req_q       <= '0;
      inflight_q  <= '0;
      busy_q      <= 1'b0;
      run_done_q  <= 1'b0;
      run_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ts_q        <= ts_d;
      deps_q      <= deps_d;
      req_q       <= req_d;
      inflight_q  <= inflight_d;
      busy_q      <= busy_d;
      run_done_q  <= run_done_d;
      run_error_q <= run_error_d;
    end
  end

  assign task_req   = req_q;
  assign busy       = busy_q;
  assign run_done   = run_done_q;
  assign run_error  = run_error_q;
  assign inflight   = inflight_q;
  assign task_state = ts_q;

endmodule

// File: tb/tb_task_dag_scheduler.sv
// Directed bench for task_dag_scheduler (8 tasks, cap of 4 in flight).
module tb_task_dag_scheduler;

  localparam int unsigned N   = 8;
  localparam int unsigned MAX = 4;
  localparam int unsigned CW  = $clog2(N + 1);

  logic            clk;
  logic            rst;
  logic            run_start;
  logic            abort;
  logic [N*N-1:0]  dep_matrix;
  logic [N-1:0]    task_en;
  logic [N-1:0]    task_req;
  logic [N-1:0]    task_ack;
  logic [N-1:0]    task_done;
  logic            busy;
  logic            run_done;
  logic            run_error;
  logic [CW-1:0]   inflight;
  logic [2*N-1:0]  task_state;

  int n_checks = 0;
  int n_errs   = 0;

  task_dag_scheduler #(.NUM_TASKS(N), .MAX_INFLIGHT(MAX)) dut (
    .clk        (clk),
    .rst        (rst),
    .run_start  (run_start),
    .abort      (abort),
    .dep_matrix (dep_matrix),
    .task_en    (task_en),
    .task_req   (task_req),
    .task_ack   (task_ack),
    .task_done  (task_done),
    .busy       (busy),
    .run_done   (run_done),
    .run_error  (run_error),
    .inflight   (inflight),
    .task_state (task_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [N*N-1:0] deps, input logic [N-1:0] en);
    dep_matrix = deps;
    task_en    = en;
    run_start  = 1'b1;
    tick();
    run_start  = 1'b0;
  endtask

  // Ack task k, let it run three cycles, then pulse its done.
  task automatic serve(input int k);
    task_ack[k] = 1'b1;
    tick();
    task_ack[k] = 1'b0;
    tick();
    tick();
    task_done[k] = 1'b1;
    tick();
    task_done[k] = 1'b0;
  endtask

  function automatic logic [N-1:0] running_mask(input logic [2*N-1:0] ts);
    logic [N-1:0] m;
    m = '0;
    for (int i = 0; i < N; i++) m[i] = (ts[2*i +: 2] == 2'd2);
    return m;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_req"},   64'(task_req),   64'h0);
    check({tag, "_busy"},  64'(busy),       64'h0);
    check({tag, "_done"},  64'(run_done),   64'h0);
    check({tag, "_err"},   64'(run_error),  64'h0);
    check({tag, "_infl"},  64'(inflight),   64'h0);
    check({tag, "_state"}, 64'(task_state), 64'h0);
  endtask

  initial begin
    logic [N*N-1:0] d;
    int             done_pulses;
    int             err_pulses;
    int             max_infl;
    bit             finished;

    rst = 1'b1; run_start = 1'b0; abort = 1'b0;
    dep_matrix = '0; task_en = '0; task_ack = '0; task_done = '0;
    tick();
    tick();
    rst = 1'b0;
    check_idle("reset");

    // Chain 0 -> 1 -> 2, other tasks disabled.
    d = '0; d[1*N+0] = 1'b1; d[2*N+1] = 1'b1;
    start_run(d, 8'b0000_0111);
    check("chain_busy_e0", 64'(busy), 64'h1);
    check("chain_req_e0",  64'(task_req), 64'h0);
    tick();
    check("chain_req0",  64'(task_req), 64'h01);
    check("chain_infl0", 64'(inflight), 64'h1);
    serve(0);
    check("chain_gap0",  64'(task_req), 64'h0);
    check("chain_st0",   64'(task_state), 64'hFFC3);
    tick();
    check("chain_req1",  64'(task_req), 64'h02);
    serve(1);
    check("chain_gap1",  64'(task_req), 64'h0);
    tick();
    check("chain_req2",  64'(task_req), 64'h04);
    serve(2);
    check("chain_rdone", 64'(run_done), 64'h1);
    check("chain_busyf", 64'(busy), 64'h1);
    check("chain_stf",   64'(task_state), 64'hFFFF);
    tick();
    check("chain_rdone_off", 64'(run_done), 64'h0);
    check("chain_idle",      64'(busy), 64'h0);
    check("chain_infl_end",  64'(inflight), 64'h0);

    // Fan-out against the in-flight cap, then abort with two tasks RUNNING.
    start_run('0, 8'hFF);
    tick(); check("fan_req1", 64'(task_req), 64'h01);
    tick(); check("fan_req2", 64'(task_req), 64'h03);
    tick(); check("fan_req3", 64'(task_req), 64'h07);
    tick(); check("fan_req4", 64'(task_req), 64'h0F);
    check("fan_infl4", 64'(inflight), 64'h4);
    tick(); check("fan_cap",  64'(task_req), 64'h0F);
    check("fan_cap_infl", 64'(inflight), 64'h4);
    task_ack = 8'h01;
    tick(); task_ack = '0;
    check("fan_ack_req",  64'(task_req), 64'h0E);
    check("fan_ack_infl", 64'(inflight), 64'h4);
    task_done = 8'h01;
    tick(); task_done = '0;
    check("fan_done_req",  64'(task_req), 64'h0E);
    check("fan_done_infl", 64'(inflight), 64'h3);
    tick();
    check("fan_fifth",      64'(task_req), 64'h1E);
    check("fan_fifth_infl", 64'(inflight), 64'h4);
    task_ack = 8'h06;
    tick(); task_ack = '0;
    check("fan_run2_req", 64'(task_req), 64'h18);
    abort = 1'b1;
    tick(); abort = 1'b0;
    check_idle("abort");

    // All tasks disabled: one RUN cycle, then FINISH.
    start_run('0, 8'h00);
    check("none_busy", 64'(busy), 64'h1);
    tick();
    check("none_rdone", 64'(run_done), 64'h1);
    check("none_busyf", 64'(busy), 64'h1);
    check("none_state", 64'(task_state), 64'hFFFF);
    tick();
    check("none_idle", 64'(busy), 64'h0);

    // Reset in the middle of a run with two tasks RUNNING.
    start_run('0, 8'b0000_0011);
    tick(); tick();
    check("rst_req2", 64'(task_req), 64'h03);
    task_ack = 8'h03;
    tick(); task_ack = '0;
    check("rst_infl2", 64'(inflight), 64'h2);
    rst = 1'b1;
    tick(); rst = 1'b0;
    check_idle("midrst");

    // Two-task cycle deadlocks one cycle after RUN entry.
    d = '0; d[0*N+1] = 1'b1; d[1*N+0] = 1'b1;
    start_run(d, 8'b0000_0011);
    check("cyc_busy", 64'(busy), 64'h1);
    tick();
    check("cyc_err",  64'(run_error), 64'h1);
    check("cyc_busy0", 64'(busy), 64'h0);
    check("cyc_req",  64'(task_req), 64'h0);
    tick();
    check("cyc_err_off", 64'(run_error), 64'h0);

    // Task 0 disabled, task 1 depends on it: task 1 issues first.
    d = '0; d[1*N+0] = 1'b1;
    start_run(d, 8'hFE);
    tick();
    check("en_first", 64'(task_req), 64'h02);
    done_pulses = 0; err_pulses = 0; max_infl = 0; finished = 1'b0;
    for (int c = 0; c < 200 && !finished; c++) begin
      task_ack  = task_req;
      task_done = running_mask(task_state);
      tick();
      if (int'(inflight) > max_infl) max_infl = int'(inflight);
      if (run_done)  done_pulses++;
      if (run_error) err_pulses++;
      if (!busy) finished = 1'b1;
    end
    task_ack = '0; task_done = '0;
    check("en_finished", 64'(finished), 64'h1);
    check("en_rdone_cnt", 64'(done_pulses), 64'h1);
    check("en_err_cnt", 64'(err_pulses), 64'h0);
    check("en_cap", 64'(max_infl <= MAX), 64'h1);
    check("en_state", 64'(task_state), 64'hFFFF);

    // run_start while busy, done for a WAIT task, ack with req low: ignored.
    d = '0; d[1*N+0] = 1'b1;
    start_run(d, 8'b0000_0011);
    tick();
    check("ign_req", 64'(task_req), 64'h01);
    check("ign_st0", 64'(task_state), 64'hFFF1);
    run_start = 1'b1; task_done = 8'h02; task_ack = 8'h02;
    tick();
    run_start = 1'b0; task_done = '0; task_ack = '0;
    check("ign_st1",   64'(task_state), 64'hFFF1);
    check("ign_req1",  64'(task_req), 64'h01);
    check("ign_busy",  64'(busy), 64'h1);
    check("ign_infl",  64'(inflight), 64'h1);
    abort = 1'b1;
    tick(); abort = 1'b0;
    check("ign_abort", 64'(busy), 64'h0);
    abort = 1'b1;
    tick(); abort = 1'b0;
    check("idle_abort_busy", 64'(busy), 64'h0);
    check("idle_abort_err",  64'(run_error), 64'h0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/task_dag_scheduler.md
# task_dag_scheduler

Parametrised dependency scheduler for batch task graphs: it takes up to NUM_TASKS task cells plus a dependency matrix and issues each task only after all of its predecessors have completed. Dependencies can be data edges (one task's output file is another's input) or pure ordering edges between cells with no IO. The block sits between the top-level batch controller and the per-task launch/complete handshakes. Over the earlier fixed three-cell graph it adds a configurable task count, a concurrency cap, task enables, abort, and deadlock detection.

## Interface
- NUM_TASKS, 8, number of task slots (2..16)
- MAX_INFLIGHT, 4, maximum tasks in ISSUED or RUNNING at once (1..NUM_TASKS)
- CNT_W, $clog2(NUM_TASKS+1), width of the in-flight count

- clk  in  1  single clock; all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- run_start  in  1  starts a run; sampled only in IDLE
- abort  in  1  cancels the run in progress
- dep_matrix  in  NUM_TASKS*NUM_TASKS  bit [i*NUM_TASKS+j]=1: task i waits for task j; captured with run_start
- task_en  in  NUM_TASKS  participating tasks, captured with run_start; a disabled task counts as DONE
- task_req  out  NUM_TASKS  launch request per task, held until acked
- task_ack  in  NUM_TASKS  launch accepted; meaningful only while the matching req is high
- task_done  in  NUM_TASKS  one-cycle completion pulse per task
- busy  out  1  high from RUN through FINISH
- run_done  out  1  one-cycle pulse when all tasks are DONE
- run_error  out  1  one-cycle pulse on deadlock
- inflight  out  CNT_W  number of tasks in ISSUED or RUNNING
- task_state  out  2*NUM_TASKS  per-task state: 0 WAIT, 1 ISSUED, 2 RUNNING, 3 DONE

## Operation
- Global FSM: IDLE, RUN, FINISH.
  - IDLE -> RUN on run_start.
  - RUN -> FINISH when all tasks are DONE.
  - RUN -> IDLE on abort or deadlock.
  - FINISH -> IDLE unconditionally after one cycle.
- On run_start: latch dep_matrix and task_en. Enabled tasks go to WAIT; disabled tasks go to DONE.
- A task is eligible when it is in WAIT and every task it depends on is DONE. A self-dependency is never satisfied.
- Issue: in RUN, at most one task per cycle moves WAIT -> ISSUED (task_req rises). The lowest-index eligible task wins. No issue happens if inflight == MAX_INFLIGHT.
- ISSUED -> RUNNING when task_ack=1 is sampled; task_req falls on the same edge.
- RUNNING -> DONE when task_done=1 is sampled.
- Ignored inputs: task_done in any other state; task_ack while req is low.
- If ack and done arrive on the same edge for an ISSUED task, only the ack is taken.
- inflight updates each edge: +1 for an issue, -1 for a completion; both on one edge give a net change of 0. The result never exceeds MAX_INFLIGHT.
- Deadlock: in RUN with inflight==0, no eligible task, and not all tasks DONE -> pulse run_error, go to IDLE. Caused by cycles, self-dependencies, or dependencies on a disabled-then-... no: disabled tasks are DONE, so only cycles and self-dependencies.
- Abort in RUN: next edge clears all task_req and goes to IDLE. No run_done, no run_error.
- Abort in IDLE or FINISH is ignored.
- run_start while busy is ignored.
- Tasks already RUNNING when the run leaves RUN are not tracked further.

## Timing
- Reset (rst=1 at an edge): state IDLE; task_req=0, busy=0, run_done=0, run_error=0, inflight=0, all task_state=WAIT. Reset mid-run takes effect at the next edge and overrides everything else.
- Edge E0 samples run_start; busy=1 after E0. The first task_req rises after E0+1.
- Done-to-successor: task_done sampled at edge Em -> task DONE after Em -> successor task_req high after Em+1.
- Peak issue rate is one task per cycle.
- Last task_done sampled at edge Ef -> FINISH after Ef with run_done=1 and busy=1 -> IDLE after Ef+1 with busy=0.
- A run with all tasks disabled: RUN for one cycle, then FINISH.
- Deadlock is detected in the first cycle its condition holds; run_error=1 for that one cycle, busy=0 after the same edge.
- task_req never drops without a sampled ack, except on abort or rst.

## Test plan
- Chain (NUM_TASKS=3, deps 1<-0, 2<-1, immediate acks, done 3 cycles after ack) -> reqs strictly serial; each successor req exactly 2 edges after its predecessor's done; single run_done pulse.
- Fan-out: 8 independent tasks, MAX_INFLIGHT=4, acks held off -> 4 reqs rise on 4 consecutive cycles, inflight=4, no fifth req until a done arrives.
- Cycle: deps 0<-1 and 1<-0 -> run_error pulse 1 cycle after RUN entry, busy=0, no task_req ever asserted.
- task_en=8'b1111_1110 with task 1 depending on task 0 -> task 1 issues first cycle; run completes normally.
- Abort, and separately rst, with 2 tasks RUNNING -> all outputs return to reset values after one edge; no run_done; a following run_start runs cleanly.
- run_start pulsed while busy, plus task_done pulsed for a WAIT task -> both ignored; task states unchanged.
